// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor constants, load queue entry type and load data formatter
package proc_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic [1:0]        offset;
    } ld_entry_t;

    // Halfwords use offset[1] only; misaligned halfwords are rejected before issue.
    function automatic logic [XLEN-1:0] format_load(input logic [2:0]      funct3,
                                                    input logic [1:0]      offset,
                                                    input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   format_load = {{24{b[7]}}, b};
            F3_LBU:  format_load = {24'b0, b};
            F3_LH:   format_load = {{16{h[15]}}, h};
            F3_LHU:  format_load = {16'b0, h};
            default: format_load = word;
        endcase
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - ALU, load issue, memory response and register-file write bundle
interface writeback_unit_if #(
    parameter int DEPTH = 4
);
    import proc_pkg::*;

    logic                    alu_valid;
    logic [REG_AW-1:0]       alu_rd;
    logic [XLEN-1:0]         alu_data;

    logic                    ld_req_valid;
    logic                    ld_req_ready;
    logic [REG_AW-1:0]       ld_req_rd;
    logic [2:0]              ld_req_funct3;
    logic [1:0]              ld_req_offset;

    logic                    mem_rsp_valid;
    logic                    mem_rsp_ready;
    logic [XLEN-1:0]         mem_rsp_data;

    logic                    rf_we;
    logic [REG_AW-1:0]       rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
    logic [31:0]             busy_mask;
    logic [$clog2(DEPTH):0]  pending_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_req_valid, ld_req_rd, ld_req_funct3, ld_req_offset,
        input  ld_req_ready,
        output mem_rsp_valid, mem_rsp_data,
        input  mem_rsp_ready,
        input  rf_we, rf_waddr, rf_wdata, busy_mask, pending_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_req_valid, ld_req_rd, ld_req_funct3, ld_req_offset,
        output ld_req_ready,
        input  mem_rsp_valid, mem_rsp_data,
        output mem_rsp_ready,
        output rf_we, rf_waddr, rf_wdata, busy_mask, pending_count
    );

endinterface

// File: rtl/writeback_unit_load_queue.sv
// rtl/writeback_unit_load_queue.sv - in-order FIFO of outstanding loads with per-entry rd compare
module load_queue
    import proc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  ld_entry_t         push_entry,
    input  logic              pop,
    output ld_entry_t         head,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    input  logic [REG_AW-1:0] cmp_rd,
    output logic [DEPTH-1:0]  rd_match
);

    ld_entry_t     entries [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] rel;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = entries[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) entries[wr_ptr[AW-1:0]] <= push_entry;
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        rd_match = '0;
        rel      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel         = AW'(i) - rd_ptr[AW-1:0];
            rd_match[i] = ({1'b0, rel} < count) && (entries[i].rd == cmp_rd);
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register-file write port arbiter for ALU results and in-order load returns
module writeback_unit
    import proc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    writeback_unit_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    ld_entry_t         q_head;
    ld_entry_t         q_push_entry;
    logic              q_full;
    logic              q_empty;
    logic [CW-1:0]     q_count;
    logic [DEPTH-1:0]  q_match;

    logic              hold_valid;
    logic [REG_AW-1:0] hold_rd;
    logic [XLEN-1:0]   hold_data;

    logic              ld_push;
    logic              rsp_accept;
    logic              hold_drain;

    logic              rf_we_q;
    logic [REG_AW-1:0] rf_waddr_q;
    logic [XLEN-1:0]   rf_wdata_q;
    logic [31:0]       busy_q;
    logic [31:0]       busy_next;

    assign q_push_entry = '{rd: bus.ld_req_rd, funct3: bus.ld_req_funct3, offset: bus.ld_req_offset};

    load_queue #(.DEPTH(DEPTH)) u_load_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (ld_push),
        .push_entry (q_push_entry),
        .pop        (rsp_accept),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count),
        .cmp_rd     (hold_rd),
        .rd_match   (q_match)
    );

    // A full hold register only blocks responses when the ALU also takes the write port.
    assign bus.ld_req_ready  = !rst && !q_full;
    assign bus.mem_rsp_ready = !rst && !q_empty && (!hold_valid || !bus.alu_valid);

    assign ld_push    = bus.ld_req_valid && bus.ld_req_ready;
    assign rsp_accept = bus.mem_rsp_valid && bus.mem_rsp_ready;
    assign hold_drain = hold_valid && !bus.alu_valid;

    always_comb begin
        busy_next = busy_q;
        if (hold_drain && !(|q_match)) busy_next[hold_rd] = 1'b0;
        if (ld_push && (bus.ld_req_rd != '0)) busy_next[bus.ld_req_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
            busy_q     <= '0;
        end else begin
            busy_q <= busy_next;

            if (bus.alu_valid) begin
                rf_we_q    <= (bus.alu_rd != '0);
                rf_waddr_q <= bus.alu_rd;
                rf_wdata_q <= bus.alu_data;
            end else if (hold_valid) begin
                rf_we_q    <= (hold_rd != '0);
                rf_waddr_q <= hold_rd;
                rf_wdata_q <= hold_data;
            end else begin
                rf_we_q    <= 1'b0;
            end

            if (rsp_accept) begin
                hold_valid <= 1'b1;
                hold_rd    <= q_head.rd;
                hold_data  <= format_load(q_head.funct3, q_head.offset, bus.mem_rsp_data);
            end else if (hold_drain) begin
                hold_valid <= 1'b0;
            end
        end
    end

    assign bus.rf_we         = rf_we_q;
    assign bus.rf_waddr      = rf_waddr_q;
    assign bus.rf_wdata      = rf_wdata_q;
    assign bus.busy_mask     = busy_q;
    assign bus.pending_count = q_count + {{(CW-1){1'b0}}, hold_valid};

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed and randomized bench for writeback_unit against a queue-based model
module tb_writeback_unit;
    import proc_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_unit_if #(.DEPTH(DEPTH)) bus ();
    writeback_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } mload_t;

    mload_t      mq[$];
    bit          h_v = 1'b0;
    logic [4:0]  h_rd;
    logic [31:0] h_data;
    logic        e_we = 1'b0;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        longint v;
        case (f3)
            3'b000, 3'b100: begin
                v = longint'((w >> (8 * off)) & 32'hFF);
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = longint'((off >= 2'd2 ? (w >> 16) : w) & 32'hFFFF);
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    // A register is busy exactly while some queued or held load still targets it.
    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        foreach (mq[i]) if (mq[i].rd != 5'd0) b[mq[i].rd] = 1'b1;
        if (h_v && h_rd != 5'd0) b[h_rd] = 1'b1;
        return b;
    endfunction

    task automatic clr();
        bus.alu_valid     = 1'b0;
        bus.alu_rd        = '0;
        bus.alu_data      = '0;
        bus.ld_req_valid  = 1'b0;
        bus.ld_req_rd     = '0;
        bus.ld_req_funct3 = '0;
        bus.ld_req_offset = '0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_data = d;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        bus.ld_req_valid = 1'b1; bus.ld_req_rd = rd; bus.ld_req_funct3 = f3; bus.ld_req_offset = off;
    endtask

    task automatic rsp(input logic [31:0] d);
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = d;
    endtask

    task automatic model_clear();
        mq.delete();
        h_v  = 1'b0;
        e_we = 1'b0;
    endtask

    task automatic cycle();
        bit          e_ldr, e_mr, push, acc;
        logic        av;
        logic [4:0]  ard, lrd;
        logic [31:0] ad, md;
        logic [2:0]  lf;
        logic [1:0]  lo;
        mload_t      e;
        #1;
        e_ldr = (mq.size() < DEPTH);
        e_mr  = (mq.size() > 0) && (!h_v || !bus.alu_valid);
        chk("ld_req_ready", 32'(bus.ld_req_ready), 32'(e_ldr));
        chk("mem_rsp_ready", 32'(bus.mem_rsp_ready), 32'(e_mr));
        push = bus.ld_req_valid && e_ldr;
        acc  = bus.mem_rsp_valid && e_mr;
        av = bus.alu_valid; ard = bus.alu_rd; ad = bus.alu_data;
        lrd = bus.ld_req_rd; lf = bus.ld_req_funct3; lo = bus.ld_req_offset;
        md = bus.mem_rsp_data;
        @(posedge clk);
        if (av) begin
            e_we = (ard != 5'd0); e_waddr = ard; e_wdata = ad;
        end else if (h_v) begin
            e_we = (h_rd != 5'd0); e_waddr = h_rd; e_wdata = h_data; h_v = 1'b0;
        end else begin
            e_we = 1'b0;
        end
        if (acc) begin
            e = mq.pop_front();
            h_v = 1'b1; h_rd = e.rd; h_data = ref_fmt(e.f3, e.off, md);
        end
        if (push) mq.push_back('{rd: lrd, f3: lf, off: lo});
        #1;
        chk("rf_we", 32'(bus.rf_we), 32'(e_we));
        if (e_we) begin
            chk("rf_waddr", 32'(bus.rf_waddr), 32'(e_waddr));
            chk("rf_wdata", bus.rf_wdata, e_wdata);
        end
        chk("busy_mask", bus.busy_mask, m_busy());
        chk("pending_count", 32'(bus.pending_count), 32'(mq.size() + int'(h_v)));
    endtask

    initial begin
        clr();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
        chk("rst_busy", bus.busy_mask, 32'd0);
        chk("rst_pending", 32'(bus.pending_count), 32'd0);
        chk("rst_ld_ready", 32'(bus.ld_req_ready), 32'd0);
        chk("rst_rsp_ready", 32'(bus.mem_rsp_ready), 32'd0);
        rst = 1'b0;

        // ALU path
        alu(5'd5, 32'h12345678); cycle();
        chk("alu_we", 32'(bus.rf_we), 32'd1);
        chk("alu_waddr", 32'(bus.rf_waddr), 32'd5);
        chk("alu_wdata", bus.rf_wdata, 32'h12345678);
        clr(); alu(5'd0, 32'hDEADBEEF); cycle();
        chk("alu_rd0_we", 32'(bus.rf_we), 32'd0);

        // Formatting, full queue
        clr(); ld(5'd1, F3_LB, 2'd3);  cycle();
        clr(); ld(5'd2, F3_LBU, 2'd3); cycle();
        clr(); ld(5'd3, F3_LH, 2'd2);  cycle();
        clr(); ld(5'd4, F3_LHU, 2'd2); cycle();
        clr(); ld(5'd9, F3_LW, 2'd0);  cycle();
        chk("full_ld_ready", 32'(bus.ld_req_ready), 32'd0);
        chk("full_pending", 32'(bus.pending_count), 32'd4);
        chk("full_busy", bus.busy_mask, 32'h0000_001E);
        clr(); rsp(32'h80FF7F01); cycle();
        chk("ready_after_pop", 32'(bus.ld_req_ready), 32'd1);
        cycle(); chk("fmt_lb", bus.rf_wdata, 32'hFFFFFF80);
        cycle(); chk("fmt_lbu", bus.rf_wdata, 32'h00000080);
        cycle(); chk("fmt_lh", bus.rf_wdata, 32'hFFFF80FF);
        clr(); cycle(); chk("fmt_lhu", bus.rf_wdata, 32'h000080FF);
        clr(); ld(5'd6, F3_LW, 2'd0); cycle();
        clr(); rsp(32'h80FF7F01); cycle();
        clr(); cycle(); chk("fmt_lw", bus.rf_wdata, 32'h80FF7F01);

        // ALU conflict with a held load
        clr(); ld(5'd8, F3_LW, 2'd0); cycle();
        clr(); ld(5'd11, F3_LW, 2'd0); cycle();
        clr(); rsp(32'hCAFEF00D); cycle();
        clr(); alu(5'd9, 32'h99); rsp(32'h0B0B0B0B); #1;
        chk("conflict_rsp_ready1", 32'(bus.mem_rsp_ready), 32'd0);
        cycle(); chk("conflict_alu1", 32'(bus.rf_waddr), 32'd9);
        clr(); alu(5'd10, 32'hAA); rsp(32'h0B0B0B0B); #1;
        chk("conflict_rsp_ready2", 32'(bus.mem_rsp_ready), 32'd0);
        cycle(); chk("conflict_alu2", 32'(bus.rf_waddr), 32'd10);
        clr(); cycle();
        chk("conflict_ld_waddr", 32'(bus.rf_waddr), 32'd8);
        chk("conflict_ld_wdata", bus.rf_wdata, 32'hCAFEF00D);
        clr(); rsp(32'h0B0B0B0B); cycle();
        clr(); cycle();

        // Same destination twice
        clr(); ld(5'd7, F3_LW, 2'd0); cycle();
        clr(); ld(5'd7, F3_LW, 2'd0); cycle();
        clr(); rsp(32'h11111111); cycle();
        rsp(32'h22222222); cycle();
        chk("waw_first", bus.rf_wdata, 32'h11111111);
        chk("waw_busy_kept", 32'(bus.busy_mask[7]), 32'd1);
        clr(); cycle();
        chk("waw_second", bus.rf_wdata, 32'h22222222);
        chk("waw_busy_clear", 32'(bus.busy_mask[7]), 32'd0);

        // Reset with outstanding work
        clr(); ld(5'd12, F3_LW, 2'd0); cycle();
        ld(5'd13, F3_LW, 2'd0); cycle();
        ld(5'd14, F3_LW, 2'd0); cycle();
        ld(5'd15, F3_LW, 2'd0); cycle();
        clr(); rsp(32'h33333333); cycle();
        clr(); #2; rst = 1'b1; #1;
        chk("mid_rst_we", 32'(bus.rf_we), 32'd0);
        chk("mid_rst_busy", bus.busy_mask, 32'd0);
        chk("mid_rst_pending", 32'(bus.pending_count), 32'd0);
        chk("mid_rst_wdata", bus.rf_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        rsp(32'h44444444); cycle();
        chk("post_rst_rsp_ready", 32'(bus.mem_rsp_ready), 32'd0);
        cycle(); cycle();
        chk("post_rst_we", 32'(bus.rf_we), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            clr();
            if ($urandom_range(0, 2) == 0) alu(5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 1) == 0)
                ld(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0) rsp($urandom);
            cycle();
        end
        clr();
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
